// File: rtl/midi_spi_event_rx.sv
// SPI MIDI receiver: synchronises SCLK/MOSI, assembles bytes, parses running-status
// MIDI into note/CC events, filters by channel and queues them in a FWFT FIFO.
module midi_spi_event_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int LVL_W       = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_SPI_sclk,
    input  logic             i_SPI_mosi,
    input  logic [15:0]      i_ch_mask,
    output logic             o_evt_valid,
    input  logic             i_evt_ready,
    output logic [1:0]       o_evt_type,
    output logic [3:0]       o_evt_ch,
    output logic [6:0]       o_evt_d1,
    output logic [6:0]       o_evt_d2,
    output logic [1:0]       o_byte_counter,
    output logic [LVL_W-1:0] o_fifo_level,
    output logic             o_overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        EVT_NOTE_OFF = 2'd0,
        EVT_NOTE_ON  = 2'd1,
        EVT_CC       = 2'd2
    } evt_type_e;

    typedef struct packed {
        evt_type_e  typ;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
    } evt_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic [6:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   byte_stb_q, byte_stb_d;
    logic [7:0]             byte_q, byte_d;
    logic [7:0]             rs_q, rs_d;
    logic                   rs_valid_q, rs_valid_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [6:0]             d1_q, d1_d;
    logic                   push_q, push_d;
    evt_t                   pend_q, pend_d;
    evt_t                   mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   pop, push, full, wr_en;
    evt_t                   head;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_SPI_sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_mosi};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_stb_d  = 1'b0;
        byte_d      = byte_q;
        if (sclk_sync_q[SYNC_STAGES-1] && !sclk_prev_q) begin
            // 3-bit count wraps to 0 on the 8th bit
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[5:0], mosi_sync_q[SYNC_STAGES-1]};
            if (bit_cnt_q == 3'd7) begin
                byte_stb_d = 1'b1;
                byte_d     = {shift_q, mosi_sync_q[SYNC_STAGES-1]};
            end
        end
    end

    always_comb begin
        rs_d       = rs_q;
        rs_valid_d = rs_valid_q;
        byte_cnt_d = byte_cnt_q;
        d1_d       = d1_q;
        push_d     = 1'b0;
        pend_d     = pend_q;
        if (byte_stb_q) begin
            if (byte_q[7]) begin
                if (byte_q[7:4] != 4'hF) begin
                    rs_d       = byte_q;
                    rs_valid_d = 1'b1;
                    byte_cnt_d = 2'd0;
                end else if (!byte_q[3]) begin
                    rs_valid_d = 1'b0;
                    byte_cnt_d = 2'd0;
                end
            end else if (rs_valid_q) begin
                if (byte_cnt_q == 2'd0) begin
                    d1_d       = byte_q[6:0];
                    byte_cnt_d = (rs_q[7:5] == 3'b110) ? 2'd0 : 2'd1;
                end else begin
                    byte_cnt_d = 2'd0;
                    pend_d.ch  = rs_q[3:0];
                    pend_d.d1  = d1_q;
                    pend_d.d2  = byte_q[6:0];
                    case (rs_q[7:4])
                        4'h8: begin push_d = 1'b1; pend_d.typ = EVT_NOTE_OFF; end
                        4'h9: begin
                            push_d     = 1'b1;
                            pend_d.typ = (byte_q[6:0] == 7'd0) ? EVT_NOTE_OFF : EVT_NOTE_ON;
                        end
                        4'hB: begin push_d = 1'b1; pend_d.typ = EVT_CC; end
                        default: push_d = 1'b0;
                    endcase
                end
            end
        end
    end

    // Channel mask is applied in the push cycle, not when the message completes
    always_comb begin
        pop        = (count_q != '0) && i_evt_ready;
        push       = push_q && i_ch_mask[pend_q.ch];
        full       = (count_q == LVL_W'(FIFO_DEPTH));
        wr_en      = push && (!full || pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + {{(LVL_W-1){1'b0}}, wr_en} - {{(LVL_W-1){1'b0}}, pop};
        overflow_d = overflow_q | (push && full && !pop);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            byte_stb_q  <= 1'b0;
            byte_q      <= '0;
            rs_q        <= '0;
            rs_valid_q  <= 1'b0;
            byte_cnt_q  <= '0;
            d1_q        <= '0;
            push_q      <= 1'b0;
            pend_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_stb_q  <= byte_stb_d;
            byte_q      <= byte_d;
            rs_q        <= rs_d;
            rs_valid_q  <= rs_valid_d;
            byte_cnt_q  <= byte_cnt_d;
            d1_q        <= d1_d;
            push_q      <= push_d;
            pend_q      <= pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= pend_q;
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign o_evt_valid    = (count_q != '0);
    assign o_evt_type     = head.typ;
    assign o_evt_ch       = head.ch;
    assign o_evt_d1       = head.d1;
    assign o_evt_d2       = head.d2;
    assign o_byte_counter = byte_cnt_q;
    assign o_fifo_level   = count_q;
    assign o_overflow     = overflow_q;
endmodule

// File: tb/tb_midi_spi_event_rx.sv
// Bench for midi_spi_event_rx: directed scenarios plus random MIDI byte streams,
// scored against a message-level MIDI model and an expected-event queue.
module tb_midi_spi_event_rx;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, mosi;
    logic [15:0] mask;
    logic        evt_ready;
    logic        o_evt_valid;
    logic [1:0]  o_evt_type;
    logic [3:0]  o_evt_ch;
    logic [6:0]  o_evt_d1, o_evt_d2;
    logic [1:0]  o_byte_counter;
    logic [3:0]  o_fifo_level;
    logic        o_overflow;

    int checks   = 0;
    int failures = 0;
    int ready_mode = 0;  // 0 low, 1 high, 2 random

    // model state
    logic [19:0] exp_q[$];
    logic [7:0]  m_rs;
    bit          m_rs_ok;
    int          m_cnt;
    logic [6:0]  m_d1;
    bit          m_ovf;

    midi_spi_event_rx #(.SYNC_STAGES(2), .FIFO_DEPTH(DEPTH), .LVL_W(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_SPI_sclk(sclk), .i_SPI_mosi(mosi),
        .i_ch_mask(mask), .o_evt_valid(o_evt_valid), .i_evt_ready(evt_ready),
        .o_evt_type(o_evt_type), .o_evt_ch(o_evt_ch), .o_evt_d1(o_evt_d1),
        .o_evt_d2(o_evt_d2), .o_byte_counter(o_byte_counter),
        .o_fifo_level(o_fifo_level), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rs = 8'h00; m_rs_ok = 0; m_cnt = 0; m_d1 = 7'd0; m_ovf = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int kind;
        logic [1:0] t;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin m_rs_ok = 0; m_cnt = 0; return; end
        if (b >= 8'h80) begin m_rs = b; m_rs_ok = 1; m_cnt = 0; return; end
        if (!m_rs_ok) return;
        kind = int'(m_rs[7:4]);
        if (m_cnt == 0) begin
            m_d1 = b[6:0];
            m_cnt = (kind == 12 || kind == 13) ? 0 : 1;
            return;
        end
        m_cnt = 0;
        if (kind == 8) t = 2'd0;
        else if (kind == 9) t = (b == 8'h00) ? 2'd0 : 2'd1;
        else if (kind == 11) t = 2'd2;
        else return;
        if (!mask[m_rs[3:0]]) return;
        if (exp_q.size() >= DEPTH) m_ovf = 1;
        else exp_q.push_back({t, m_rs[3:0], m_d1, b[6:0]});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit measure);
        model_byte(b);
        for (int i = 7; i >= 0; i--) begin
            @(posedge clk); #1; mosi = b[i];
            repeat (3) @(posedge clk);
            #1; sclk = 1'b1;
            if (measure && i == 0) begin
                repeat (5) @(negedge clk);
                chk("latency_n_plus_1", {31'd0, o_evt_valid}, 32'd0);
                @(negedge clk);
                chk("latency_n_plus_2", {31'd0, o_evt_valid}, 32'd1);
                @(posedge clk); #1;
            end else begin
                repeat (4) @(posedge clk);
                #1;
            end
            sclk = 1'b0;
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("byte_counter", {30'd0, o_byte_counter}, m_cnt);
        chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
        if (ready_mode == 0) chk("fifo_level", {28'd0, o_fifo_level}, exp_q.size());
    endtask

    task automatic head_is(input logic [1:0] t, input logic [3:0] c, input logic [6:0] a, input logic [6:0] d);
        chk("head", {11'd0, o_evt_valid, o_evt_type, o_evt_ch, o_evt_d1, o_evt_d2}, {11'd0, 1'b1, t, c, a, d});
    endtask

    task automatic set_ready(input int m);
        ready_mode = m;
        if (m == 0) evt_ready = 1'b0;
        if (m == 1) evt_ready = 1'b1;
    endtask

    task automatic pop_one();
        @(posedge clk); #1; evt_ready = 1'b1;
        @(posedge clk); #1; evt_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        @(posedge clk); #1; set_ready(1);
        n = 0;
        while ((o_fifo_level != 4'd0 || exp_q.size() != 0) && n < 300) begin
            @(negedge clk); n++;
        end
        chk("drain_level", {28'd0, o_fifo_level}, 32'd0);
        chk("drain_scoreboard_empty", exp_q.size(), 32'd0);
        @(posedge clk); #1; set_ready(0);
    endtask

    task automatic compare_loop();
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (!rst && o_evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_event actual=0x%0h expected=none",
                             {o_evt_type, o_evt_ch, o_evt_d1, o_evt_d2});
                end else begin
                    e = exp_q.pop_front();
                    chk("event", {12'd0, o_evt_type, o_evt_ch, o_evt_d1, o_evt_d2}, {12'd0, e});
                end
            end
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 2) evt_ready = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        logic [7:0] b;
        int r;
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; mask = 16'hFFFF; evt_ready = 1'b0;
        model_reset();
        fork
            compare_loop();
            ready_loop();
            begin
                #2ms;
                $display("FAIL watchdog actual=timeout expected=finish");
                $fatal(1, "watchdog");
            end
        join_none
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {11'd0, o_evt_valid, o_evt_type, o_evt_ch, o_evt_d1, o_evt_d2},
            32'd0);
        chk("reset_status", {24'd0, o_byte_counter, o_fifo_level, o_overflow, 1'b0}, 32'd0);

        // 1: single note on, with latency pin
        set_ready(0);
        send_byte(8'h93, 0); send_byte(8'h3C, 0); send_byte(8'h64, 1);
        head_is(2'd1, 4'd3, 7'h3C, 7'h64);
        chk("t1_level", {28'd0, o_fifo_level}, 32'd1);
        pop_one();

        // 2: running status, velocity-0 note on becomes note off
        send_byte(8'h90, 0); send_byte(8'h40, 0); send_byte(8'h7F, 0);
        send_byte(8'h40, 0); send_byte(8'h00, 0);
        chk("t2_level", {28'd0, o_fifo_level}, 32'd2);
        head_is(2'd1, 4'd0, 7'h40, 7'h7F);
        pop_one();
        head_is(2'd0, 4'd0, 7'h40, 7'h00);
        pop_one();

        // 3: realtime byte inside a CC message
        send_byte(8'hB1, 0); chk("t3_cnt0", {30'd0, o_byte_counter}, 32'd0);
        send_byte(8'h07, 0); chk("t3_cnt1", {30'd0, o_byte_counter}, 32'd1);
        send_byte(8'hF8, 0); chk("t3_cnt2", {30'd0, o_byte_counter}, 32'd1);
        send_byte(8'h55, 0); chk("t3_cnt3", {30'd0, o_byte_counter}, 32'd0);
        chk("t3_level", {28'd0, o_fifo_level}, 32'd1);
        head_is(2'd2, 4'd1, 7'h07, 7'h55);
        pop_one();

        // 4: channel mask
        mask = 16'h0001;
        send_byte(8'h92, 0); send_byte(8'h30, 0); send_byte(8'h40, 0);
        chk("t4_masked_level", {28'd0, o_fifo_level}, 32'd0);
        send_byte(8'h80, 0); send_byte(8'h30, 0); send_byte(8'h00, 0);
        chk("t4_level", {28'd0, o_fifo_level}, 32'd1);
        head_is(2'd0, 4'd0, 7'h30, 7'h00);
        pop_one();
        mask = 16'hFFFF;

        // 5: overflow with consumer stalled
        send_byte(8'h90, 0);
        for (int k = 0; k <= DEPTH; k++) begin
            send_byte(8'(8'h20 + k), 0);
            send_byte(8'(8'h10 + k), 0);
        end
        chk("t5_level", {28'd0, o_fifo_level}, DEPTH);
        chk("t5_overflow", {31'd0, o_overflow}, 32'd1);
        head_is(2'd1, 4'd0, 7'h20, 7'h10);
        drain();
        chk("t5_overflow_sticky", {31'd0, o_overflow}, 32'd1);

        // 6: reset in the middle of a byte
        for (int i = 7; i >= 3; i--) begin
            @(posedge clk); #1; mosi = b[0] ^ 1'b1; mosi = (i == 7 || i == 4);
            repeat (3) @(posedge clk); #1; sclk = 1'b1;
            repeat (4) @(posedge clk); #1; sclk = 1'b0;
        end
        @(posedge clk); #1; rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(posedge clk); #1; sclk = 1'b1;
            repeat (4) @(posedge clk); #1; sclk = 1'b0;
        end
        mosi = 1'b0;
        repeat (4) @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("t6_after_reset", {27'd0, o_evt_valid, o_byte_counter == 2'd0, o_fifo_level}, 32'h10);
        send_byte(8'h90, 0); send_byte(8'h41, 0); send_byte(8'h10, 0);
        chk("t6_level", {28'd0, o_fifo_level}, 32'd1);
        chk("t6_overflow", {31'd0, o_overflow}, 32'd0);
        head_is(2'd1, 4'd0, 7'h41, 7'h10);
        drain();

        // random MIDI streams with random consumer backpressure
        set_ready(2);
        for (int n = 0; n < 160; n++) begin
            if (n % 20 == 0) mask = 16'($urandom | $urandom);
            r = $urandom_range(0, 99);
            if (r < 10) begin
                b = {($urandom_range(0, 2) == 0) ? 4'h8 : (($urandom_range(0, 1) == 0) ? 4'h9 : 4'hB),
                     4'($urandom_range(0, 15))};
            end else if (r < 14) begin
                b = {4'($urandom_range(10, 14)), 4'($urandom_range(0, 15))};
            end else if (r < 16) begin
                b = 8'(8'hF0 + $urandom_range(0, 7));
            end else if (r < 20) begin
                b = 8'(8'hF8 + $urandom_range(0, 7));
            end else if (r < 28) begin
                b = 8'h00;
            end else begin
                b = 8'($urandom_range(0, 127));
            end
            send_byte(b, 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
